// File: rtl/sfr_timer32.sv
// 32-bit SFR-mapped timer: eight selectable tick sources, two compare matches and overflow,
// with sticky flags feeding a single registered level interrupt.
module sfr_timer32 #(
    parameter logic [31:0] RST_CNT = 32'h0,
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sfr_we,
    input  logic               sfr_re,
    input  logic [1:0]         sfr_addr,
    input  logic [31:0]        sfr_wdata,
    output logic [31:0]        sfr_rdata,
    input  logic [NUM_SRC-1:0] tick_src,
    output logic               tmr_irq,
    output logic [31:0]        tmr_val_o
);

    logic        on_q, running_q, running_d;
    logic [2:0]  clksrc_q;
    logic [2:0]  flag_q, flag_d, en_q, hw_set;
    logic        rst_p_q, ld_p_q, rd_p_q, start_p_q, stop_p_q;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] val_buf_q, snap_q, match0_q, match1_q, rdata_q, rdata_d, ctrl_rd;
    logic        irq_q;
    logic        ctrl_we, tick_sel, tick_en;

    assign ctrl_we = sfr_we && (sfr_addr == 2'd0);
    assign cnt_inc = cnt_q + 32'd1;
    assign tick_en = on_q & running_q & tick_sel;

    // Out-of-range clksrc selects nothing, so no ticks.
    always_comb begin
        tick_sel = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (32'(clksrc_q) == 32'(i)) tick_sel = tick_src[i];
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        hw_set = 3'b000;
        if (rst_p_q) begin
            cnt_d = RST_CNT;
        end else if (ld_p_q) begin
            cnt_d = val_buf_q;
        end else if (tick_en) begin
            cnt_d     = cnt_inc;
            hw_set[0] = (cnt_inc == match0_q);
            hw_set[1] = (cnt_inc == match1_q);
            hw_set[2] = (cnt_q == 32'hFFFF_FFFF);
        end
    end

    // Hardware set overrides a same-cycle software clear.
    always_comb begin
        flag_d = flag_q;
        if (ctrl_we) flag_d = sfr_wdata[15:13];
        flag_d = flag_d | hw_set;
    end

    always_comb begin
        running_d = running_q;
        if (start_p_q) running_d = 1'b1;
        if (stop_p_q)  running_d = 1'b0;
        if (!on_q)     running_d = 1'b0;
    end

    assign ctrl_rd = {8'd0, en_q, 5'd0, flag_q, 2'd0, clksrc_q, 7'd0, on_q};

    always_comb begin
        rdata_d = rdata_q;
        if (sfr_re) begin
            unique case (sfr_addr)
                2'd0: rdata_d = ctrl_rd;
                2'd1: rdata_d = snap_q;
                2'd2: rdata_d = match0_q;
                2'd3: rdata_d = match1_q;
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q      <= 1'b0;
            clksrc_q  <= 3'd0;
            en_q      <= 3'd0;
            flag_q    <= 3'd0;
            rst_p_q   <= 1'b0;
            ld_p_q    <= 1'b0;
            rd_p_q    <= 1'b0;
            start_p_q <= 1'b0;
            stop_p_q  <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= RST_CNT;
            val_buf_q <= 32'd0;
            snap_q    <= 32'd0;
            match0_q  <= 32'd0;
            match1_q  <= 32'd0;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            rst_p_q   <= ctrl_we & sfr_wdata[1];
            ld_p_q    <= ctrl_we & sfr_wdata[2];
            rd_p_q    <= ctrl_we & sfr_wdata[3];
            stop_p_q  <= ctrl_we & sfr_wdata[6];
            start_p_q <= ctrl_we & sfr_wdata[7];
            if (ctrl_we) begin
                on_q     <= sfr_wdata[0];
                clksrc_q <= sfr_wdata[10:8];
                en_q     <= sfr_wdata[23:21];
            end
            if (sfr_we && sfr_addr == 2'd1) val_buf_q <= sfr_wdata;
            if (sfr_we && sfr_addr == 2'd2) match0_q  <= sfr_wdata;
            if (sfr_we && sfr_addr == 2'd3) match1_q  <= sfr_wdata;
            if (rd_p_q) snap_q <= cnt_q;
            flag_q    <= flag_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            irq_q     <= |(flag_q & en_q);
        end
    end

    assign sfr_rdata = rdata_q;
    assign tmr_irq   = irq_q;
    assign tmr_val_o = cnt_q;

endmodule

// File: tb/tb_sfr_timer32.sv
// Self-checking bench for sfr_timer32: register table plus hand-written timing sequences,
// with read data checked through an expected-value queue.
module tb_sfr_timer32;

    localparam int unsigned NSRC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sfr_we = 1'b0, sfr_re = 1'b0;
    logic [1:0]      sfr_addr = 2'd0;
    logic [31:0]     sfr_wdata = 32'd0;
    logic [31:0]     sfr_rdata;
    logic [NSRC-1:0] tick_src = '0;
    logic            tmr_irq;
    logic [31:0]     tmr_val_o;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    sfr_timer32 #(.RST_CNT(32'h0), .NUM_SRC(NSRC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sfr_we    (sfr_we),
        .sfr_re    (sfr_re),
        .sfr_addr  (sfr_addr),
        .sfr_wdata (sfr_wdata),
        .sfr_rdata (sfr_rdata),
        .tick_src  (tick_src),
        .tmr_irq   (tmr_irq),
        .tmr_val_o (tmr_val_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic sfr_write(input logic [1:0] addr, input logic [31:0] data);
        sfr_we = 1'b1;
        sfr_addr = addr;
        sfr_wdata = data;
        cyc();
        sfr_we = 1'b0;
    endtask

    task automatic sfr_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        sfr_re = 1'b1;
        sfr_addr = addr;
        exp_q.push_back(exp);
        name_q.push_back(name);
        cyc();
        sfr_re = 1'b0;
        check(name_q.pop_front(), sfr_rdata, exp_q.pop_front());
    endtask

    task automatic tick(input int src);
        tick_src = '0;
        tick_src[src] = 1'b1;
        cyc();
        tick_src = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        vecs[0] = '{addr: 2'd2, wdata: 32'hA5A5_A5A5, exp: 32'hA5A5_A5A5};
        vecs[1] = '{addr: 2'd3, wdata: 32'h1234_5678, exp: 32'h1234_5678};
        vecs[2] = '{addr: 2'd1, wdata: 32'h0000_1234, exp: 32'h0000_0000};
        vecs[3] = '{addr: 2'd0, wdata: 32'h0000_0000, exp: 32'h0000_0000};
        vecs[4] = '{addr: 2'd0, wdata: 32'hFFFF_FFFF, exp: 32'h00E0_E701};

        do_reset();
        check("reset_val", tmr_val_o, 32'd0);
        check("reset_irq", {31'd0, tmr_irq}, 32'd0);
        check("reset_rdata", sfr_rdata, 32'd0);

        // Register map: VAL reads the snapshot, CTRL masks unused bits and strobes.
        for (int i = 0; i < 5; i++) begin
            sfr_write(vecs[i].addr, vecs[i].wdata);
            sfr_read(vecs[i].addr, vecs[i].exp, $sformatf("regmap%0d", i));
        end
        do_reset();

        // 1: count five ticks on source 2, ignore source 1, snapshot and read back.
        sfr_write(2'd0, 32'h0000_0281);
        cyc();
        for (int i = 0; i < 5; i++) tick(2);
        tick(1);
        tick(5);
        check("t1_live", tmr_val_o, 32'd5);
        sfr_write(2'd0, 32'h0000_0209);
        cyc();
        sfr_read(2'd1, 32'd5, "t1_snap");

        // 2: match0 at 3, irq one cycle later, software clear drops irq.
        sfr_write(2'd2, 32'd3);
        sfr_write(2'd0, 32'h0020_0203);
        cyc();
        check("t2_rst", tmr_val_o, 32'd0);
        for (int i = 0; i < 3; i++) tick(2);
        check("t2_cnt", tmr_val_o, 32'd3);
        check("t2_irq_lat", {31'd0, tmr_irq}, 32'd0);
        cyc();
        check("t2_irq_set", {31'd0, tmr_irq}, 32'd1);
        sfr_read(2'd0, 32'h0020_2201, "t2_flag");
        sfr_write(2'd0, 32'h0020_0201);
        check("t2_irq_hold", {31'd0, tmr_irq}, 32'd1);
        cyc();
        check("t2_irq_clr", {31'd0, tmr_irq}, 32'd0);

        // 3: load near the top, wrap sets overflow only once.
        sfr_write(2'd3, 32'h55);
        sfr_write(2'd1, 32'hFFFF_FFFE);
        sfr_write(2'd0, 32'h0080_0205);
        cyc();
        check("t3_ld", tmr_val_o, 32'hFFFF_FFFE);
        tick(2);
        tick(2);
        check("t3_wrap", tmr_val_o, 32'd0);
        cyc();
        check("t3_irq", {31'd0, tmr_irq}, 32'd1);
        sfr_read(2'd0, 32'h0080_8201, "t3_ovf");
        tick(2);
        check("t3_cnt1", tmr_val_o, 32'd1);
        sfr_read(2'd0, 32'h0080_8201, "t3_noflag");
        sfr_write(2'd0, 32'h0000_0201);

        // 4: rst beats ld and tick; ld onto match1 sets no flag; start+stop halts.
        sfr_write(2'd1, 32'h10);
        sfr_write(2'd0, 32'h0040_0207);
        tick(2);
        check("t4_rst_prio", tmr_val_o, 32'd0);
        sfr_write(2'd1, 32'h55);
        sfr_write(2'd0, 32'h0040_0205);
        cyc();
        check("t4_ld", tmr_val_o, 32'h55);
        sfr_read(2'd0, 32'h0040_0201, "t4_nomatch");
        sfr_write(2'd0, 32'h0040_02C1);
        cyc();
        tick(2);
        tick(2);
        check("t4_stopped", tmr_val_o, 32'h55);

        // 5: software clear in the same cycle as a hardware match keeps the flag.
        sfr_write(2'd0, 32'h0040_0281);
        cyc();
        sfr_write(2'd3, 32'h57);
        tick(2);
        check("t5_cnt", tmr_val_o, 32'h56);
        sfr_we = 1'b1;
        sfr_addr = 2'd0;
        sfr_wdata = 32'h0040_0201;
        tick_src[2] = 1'b1;
        cyc();
        sfr_we = 1'b0;
        tick_src = '0;
        check("t5_cnt_match", tmr_val_o, 32'h57);
        sfr_read(2'd0, 32'h0040_4201, "t5_flag_kept");
        check("t5_irq", {31'd0, tmr_irq}, 32'd1);

        // 6: async reset mid-count clears everything without a clock edge.
        tick(2);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_val", tmr_val_o, 32'd0);
        check("t6_irq", {31'd0, tmr_irq}, 32'd0);
        check("t6_rdata", sfr_rdata, 32'd0);
        #8;
        rst_n = 1'b1;
        cyc();
        tick(2);
        tick(2);
        check("t6_idle", tmr_val_o, 32'd0);
        sfr_read(2'd0, 32'd0, "t6_ctrl");
        sfr_write(2'd0, 32'h0000_0281);
        cyc();
        tick(2);
        check("t6_restart", tmr_val_o, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/sfr_timer32.md
Name: sfr_timer32

Overview:
- 32-bit general-purpose timer peripheral; consumes the timer SFR layout (CTRL, VAL, MATCH0, MATCH1) from the SFR package.
- Sits on the peripheral SFR bus below the address decoder. Counts ticks from one of eight prescaled clock-enable sources.
- Raises match-0, match-1 and overflow flags, and a single level interrupt to the interrupt controller.

Parameters:
- RST_CNT, 32'h0, counter value after reset and after a CTRL.rst pulse.
- NUM_SRC, 8, number of tick sources; clksrc selects 0..NUM_SRC-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- sfr_we  in  1  write strobe, single cycle
- sfr_re  in  1  read strobe, single cycle
- sfr_addr  in  2  register select: 0 CTRL, 1 VAL, 2 MATCH0, 3 MATCH1
- sfr_wdata  in  32  write data
- sfr_rdata  out  32  read data, registered
- tick_src  in  NUM_SRC  single-cycle count-enable pulses, synchronous to clk
- tmr_irq  out  1  level interrupt
- tmr_val_o  out  32  live counter, for debug and PWM chaining

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: counter=RST_CNT; CTRL, VAL buffer, MATCH0, MATCH1 and running = 0; sfr_rdata=0; tmr_irq=0.
- CTRL fields (bit positions):
  - on[0], rst[1], ld[2], rd[3], stop[6], start[7]
  - clksrc[10:8]
  - match0_f[13], match1_f[14], ovf_f[15]
  - match0_en[21], match1_en[22], ovf_en[23]
  - All other bits: writes ignored, read 0.
- Self-clearing strobes (rst, ld, rd, start, stop):
  - Acted on in the cycle after the write. Never stored; always read 0.
- running flag: start sets it, stop clears it. Both written together: stop wins. on=0 forces running=0.
- Count enable: on & running & tick_src[clksrc]. clksrc >= NUM_SRC means no ticks.
- Counter update priority per cycle: rst (load RST_CNT) > ld (load VAL buffer) > tick (+1, mod 2^32).
- VAL register:
  - Write stores into the load buffer only; the counter is untouched.
  - rd strobe snapshots the counter into the read-back register.
  - Read of VAL returns the snapshot, not the live count.
- Match event:
  - Fires on a tick whose next value equals MATCH0 or MATCH1; sets the corresponding flag the same cycle the counter updates.
  - ld or rst landing on a match value does not set a flag.
- Overflow: tick with counter=32'hFFFFFFFF -> counter=0, ovf_f set.
- Flags: hardware set has priority over a software write of 0 in the same cycle. Software may write 1 (sets the flag, used as a test hook).
- tmr_irq = registered OR of (flag & en); asserts 1 cycle after the flag sets; deasserts 1 cycle after clear or disable.
- MATCH0/MATCH1: plain read/write, take effect for the next tick.
- Reads: sfr_rdata valid 1 cycle after sfr_re and holds until the next sfr_re. Write and read to the same register in the same cycle returns the old value.
- Async reset mid-count: all state is returned to reset values immediately. No partial strobe effects survive.

Test Plan:
1. Reset, then write CTRL on=1, start=1, clksrc=2. Pulse tick_src[2] 5 times, then rd strobe, then read VAL -> reads 5. Ticks on other sources ignored.
2. MATCH0=3, match0_en=1, run from 0 -> match0_f set with counter=3; tmr_irq high the next cycle. Write 0 to match0_f -> irq drops 1 cycle later.
3. Write VAL=32'hFFFFFFFE, ld, ovf_en=1, two ticks -> counter 0, ovf_f=1, irq=1. A third tick -> counter 1, no new flag.
4. Same-cycle rst+ld with a tick -> counter=RST_CNT. Then ld with VAL=MATCH1 value -> no match1_f. start+stop written together -> counter does not advance.
5. Flag clear-write collides with a hardware match in the same cycle -> flag stays 1.
6. Assert rst_n low mid-count with irq high -> counter, flags, CTRL, tmr_irq and sfr_rdata all 0 asynchronously. After release, ticks ignored until start.
